mul_shift_arb: RTL and testbench
================================

// Module: mul_shift_arb
// PURPOSE
//  Round-robin arbiter and 2-stage pipeline that shares one shifter_l logical-right barrel shifter between
//  NREQ requesters in the multiplier datapath (normalisation/alignment users). Each requester uses valid/ready.
//  Results return on a single valid/ready response channel tagged with the requester id, in acceptance order.
// PARAMETERS
//  WIDTH   48               data width; legal range 33..64 (shifter_l has fixed 32/16/8/4/2/1 stages)
//  NREQ    4                number of requesters, 2..8
//  AWIDTH  $clog2(WIDTH)    shift-amount width (localparam)
//  IWIDTH  $clog2(NREQ)     requester-id width (localparam)
// PORTS
//  clk        in   1             clock
//  rst        in   1             synchronous reset, active-high
//  flush      in   1             synchronous pipeline flush
//  req_valid  in   NREQ          per-requester request valid
//  req_ready  out  NREQ          per-requester accept; one-hot or zero
//  req_data   in   NREQ*WIDTH    requester i operand at [i*WIDTH +: WIDTH]
//  req_shamt  in   NREQ*AWIDTH   requester i right-shift amount at [i*AWIDTH +: AWIDTH]
//  rsp_valid  out  1             result valid
//  rsp_ready  in   1             downstream accept
//  rsp_data   out  WIDTH         data >> shamt, zero-filled
//  rsp_id     out  IWIDTH        requester index of this result
//  busy       out  1             s1_valid | s2_valid
// BEHAVIOUR
//  Pipeline: S1 capture regs {data, shamt, id, s1_valid}; shifter_l between S1 and S2; S2 output regs = rsp_*.
//  Advance: s2_adv = ~s2_valid | rsp_ready; s1_adv = ~s1_valid | s2_adv. Full throughput 1 result/cycle.
//  Latency: request accepted in cycle n -> rsp_valid in cycle n+2 when no stall. No bubble on back-to-back accepts.
//  Arbitration: combinational round-robin over req_valid; search starts at ptr+1 and wraps modulo NREQ.
//   req_ready[i] = grant[i] & s1_adv & ~flush. ptr <= granted index only on an accept (valid & ready).
//   Requesters with valid low are skipped. Each requester waits at most NREQ-1 accepts.
//  Handshake: requester holds data/shamt stable while valid & ~ready. Dropping valid without an accept is permitted.
//   rsp_* stay stable while rsp_valid & ~rsp_ready.
//  Shift rule: shamt < WIDTH -> rsp_data = data >> shamt. shamt >= WIDTH (e.g. 48..63 at WIDTH=48) -> rsp_data = 0.
//   The zero result is forced explicitly, not left to shifter stage behaviour.
//  Stall: rsp_valid & ~rsp_ready holds S2. S1 holds if also valid. req_ready all 0 while S1 is held.
//  flush (not during rst): next cycle s1_valid = s2_valid = 0 and rsp_valid = 0; no accept in the flush cycle.
//   In-flight results are discarded silently. ptr is unchanged; data regs are don't-care.
//  Reset: s1_valid = s2_valid = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0, ptr = NREQ-1.
//   After reset requester 0 has top priority. req_ready = 0 during the rst cycle. Mid-operation reset drops all in-flight work.
//  Ordering: results leave in acceptance order; no reordering, no duplication, no loss except by flush/rst.
// TESTING
//  1 Single req: NREQ=4, req_valid=0010, data=48'hFFFF_0000_1234, shamt=4, rsp_ready=1
//    -> req_ready=0010 in cycle n; rsp_valid in n+2, rsp_data=48'h0FFF_F000_0123, rsp_id=1.
//  2 Round-robin: all 4 requesters valid for 8 cycles, rsp_ready=1
//    -> grant order 0,1,2,3,0,1,2,3; one rsp per cycle from cycle 2; ids match the grant order.
//  3 Backpressure: stream from req 0, rsp_ready=0 for 5 cycles
//    -> rsp holds first result stable; S1 fills; req_ready=0 after 2 accepts; on release no loss, no duplication.
//  4 Boundary shifts: shamt=0, 1, 47, 48, 63 on data=48'h8000_0000_0001
//    -> 48'h8000_0000_0001, 48'h4000_0000_0000, 48'h1, 0, 0.
//  5 Flush/reset: 2 results in flight; assert flush (then rst in a separate run)
//    -> next cycle rsp_valid=0, busy=0; flush keeps ptr; after rst requester 0 wins against all-valid.
//  6 Scoreboard: random valid/shamt/rsp_ready, 10k cycles
//    -> every accept yields exactly one rsp with golden (data>>shamt or 0) and correct id, in order.

Source files
------------

// File: rtl/mul_shift_arb.sv
// Round-robin arbiter feeding a shared 2-stage logical-right barrel shifter.
// Results return on one valid/ready channel, tagged with the requester id, in acceptance order.
module mul_shift_arb #(
    parameter int WIDTH = 48,
    parameter int NREQ  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*WIDTH-1:0]           req_data,
    input  logic [NREQ*$clog2(WIDTH)-1:0]   req_shamt,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [WIDTH-1:0]                rsp_data,
    output logic [$clog2(NREQ)-1:0]         rsp_id,
    output logic                            busy
);

    localparam int AWIDTH = $clog2(WIDTH);
    localparam int IWIDTH = $clog2(NREQ);

    // Logarithmic shifter; amounts at or beyond WIDTH are forced to zero rather
    // than relying on what the 32/16/8/4/2/1 stages happen to produce.
    function automatic logic [WIDTH-1:0] shift_r(input logic [WIDTH-1:0] d,
                                                  input logic [AWIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = d;
        for (int k = 0; k < AWIDTH; k++) begin
            if (s[k]) t = t >> (1 << k);
        end
        if ({1'b0, s} >= (AWIDTH+1)'(WIDTH)) t = '0;
        return t;
    endfunction

    logic              vld_p1;
    logic [WIDTH-1:0]  data_p1;
    logic [AWIDTH-1:0] shamt_p1;
    logic [IWIDTH-1:0] id_p1;

    logic [IWIDTH-1:0] ptr;
    logic [IWIDTH-1:0] gnt_idx;
    logic              gnt_found;
    logic              accept;
    logic              s1_adv;
    logic              s2_adv;
    int                idx;

    assign s2_adv = ~rsp_valid | rsp_ready;
    assign s1_adv = ~vld_p1 | s2_adv;
    assign busy   = vld_p1 | rsp_valid;

    // Round-robin search begins just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IWIDTH'(idx);
            end
        end
    end

    assign accept = gnt_found & s1_adv & ~flush & ~rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    // ---- stage p0 -> p1: capture the granted operand ----
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1  <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
            shamt_p1 <= req_shamt[int'(gnt_idx)*AWIDTH +: AWIDTH];
            id_p1    <= gnt_idx;
        end
    end

    // ---- stage p1 -> p2: shift into the response registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr       <= IWIDTH'(NREQ-1);
        end else if (flush) begin
            vld_p1    <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                rsp_valid <= vld_p1;
                if (vld_p1) begin
                    rsp_data <= shift_r(data_p1, shamt_p1);
                    rsp_id   <= id_p1;
                end
            end
            if (s1_adv) vld_p1 <= accept;
            if (accept) ptr <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_mul_shift_arb.sv
// Bench for mul_shift_arb: scenario tasks plus an in-order scoreboard on the response channel.
module tb_mul_shift_arb;

    localparam int W  = 48;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data = '0;
    logic [N*AW-1:0] req_shamt = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [W-1:0]    rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    typedef logic [IW+W-1:0] ent_t;
    ent_t q[$];

    logic          prev_stall = 1'b0;
    logic          prev_kill  = 1'b1;
    logic [W-1:0]  prev_data;
    logic [IW-1:0] prev_id;

    mul_shift_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] golden(input logic [W-1:0] d, input logic [AW-1:0] s);
        if (int'(s) >= W) return '0;
        return d >> s;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        ent_t e;
        if (prev_stall && !prev_kill) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_id !== prev_id) begin
                errors++;
                $display("FAIL rsp_stable: got v=%b id=%0d data=%h, need v=1 id=%0d data=%h",
                         rsp_valid, rsp_id, rsp_data, prev_id, prev_data);
            end
        end
        if (!rst) begin
            checks++;
            if (!$onehot0(req_ready)) begin
                errors++;
                $display("FAIL ready_onehot: got %b, need one-hot or zero", req_ready);
            end
        end
        if (rsp_valid === 1'b1 && rsp_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, need no response", rsp_id, rsp_data);
            end else begin
                e = q.pop_front();
                if ({rsp_id, rsp_data} !== e) begin
                    errors++;
                    $display("FAIL sb_data: got id=%0d data=%h, need id=%0d data=%h",
                             rsp_id, rsp_data, e[IW+W-1:W], e[W-1:0]);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] === 1'b1)
                q.push_back({IW'(i), golden(req_data[i*W +: W], req_shamt[i*AW +: AW])});
        end
        if (rst || flush) q.delete();
        prev_stall = (rsp_valid === 1'b1) && !rsp_ready;
        prev_kill  = rst || flush;
        prev_data  = rsp_data;
        prev_id    = rsp_id;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while ((q.size() != 0 || busy !== 1'b0) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending=%0d busy=%b, need 0 and 0", q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W]   = 48'h0001_0000_0000 * (i + 3);
            req_shamt[i*AW +: AW] = AW'(i + 1);
        end
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_data !== '0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b busy=%b data=%h id=%0d, need 0000 0 0 0 0",
                     req_ready, rsp_valid, busy, rsp_data, rsp_id);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_priority: got %b, need 0001", req_ready);
        end
        step();
        drain();
    endtask

    task automatic test_single();
        step();
        req_valid = 4'b0010;
        req_data[1*W +: W] = 48'hFFFF_0000_1234;
        req_shamt[1*AW +: AW] = 6'd4;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready: got %b, need 0010", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: got rsp_valid=%b, need 0", rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 48'h0FFF_F000_0123 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL single_rsp: got v=%b data=%h id=%0d, need 1 0ffff0000123 1",
                     rsp_valid, rsp_data, rsp_id);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_r;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W]   = 48'h1111_1111_1111 * (i + 1);
            req_shamt[i*AW +: AW] = AW'(i * 5);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            req_valid = 4'b1111;
            rsp_ready = 1'b1;
            @(negedge clk);
            exp_r = '0;
            exp_r[k % N] = 1'b1;
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, need %b", k, req_ready, exp_r);
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== IW'((k - 2) % N)) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: got v=%b id=%0d, need 1 %0d",
                             k, rsp_valid, rsp_id, (k - 2) % N);
                end
            end
        end
        step();
        drain();
    endtask

    task automatic test_backpressure();
        logic         acc;
        int           stall_acc;
        logic [W-1:0] v;
        acc = 1'b0;
        stall_acc = 0;
        v = 48'h0000_0000_F0F0;
        step();
        req_data[0 +: W] = v;
        req_shamt[0 +: AW] = 6'd3;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            if (acc) begin
                v = v + 48'h0001_0000_0001;
                req_data[0 +: W] = v;
                req_shamt[0 +: AW] = AW'(c % 7);
            end
            req_valid = (c < 10) ? 4'b0001 : 4'b0000;
            rsp_ready = (c >= 5);
            @(negedge clk);
            acc = req_valid[0] & req_ready[0];
            if (acc && c < 5) stall_acc++;
            if (c == 4) begin
                checks++;
                if (req_ready !== 4'b0000) begin
                    errors++;
                    $display("FAIL bp_ready_held: got %b, need 0000", req_ready);
                end
            end
        end
        checks++;
        if (stall_acc != 2) begin
            errors++;
            $display("FAIL bp_accepts: got %0d, need 2", stall_acc);
        end
        drain();
    endtask

    task automatic test_boundary();
        int           sh_tbl[5];
        logic [W-1:0] ex_tbl[5];
        int           got;
        sh_tbl = '{0, 1, 47, 48, 63};
        ex_tbl = '{48'h8000_0000_0001, 48'h4000_0000_0000, 48'h0000_0000_0001,
                   48'h0, 48'h0};
        got = 0;
        req_data[2*W +: W] = 48'h8000_0000_0001;
        for (int k = 0; k < 10; k++) begin
            step();
            rsp_ready = 1'b1;
            if (k < 5) begin
                req_valid = 4'b0100;
                req_shamt[2*AW +: AW] = AW'(sh_tbl[k]);
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (req_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL bnd_ready[%0d]: got %b, need 0100", k, req_ready);
                end
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (got >= 5 || rsp_data !== ex_tbl[got]) begin
                    errors++;
                    $display("FAIL bnd_data[%0d]: got %h, need %h", got, rsp_data,
                             (got < 5) ? ex_tbl[got] : 48'h0);
                end
                got++;
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL bnd_count: got %0d, need 5", got);
        end
        drain();
    endtask

    task automatic test_kill(input logic use_rst);
        logic [N-1:0] exp_r;
        step();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        req_data[1*W +: W] = 48'h0000_ABCD_0000;
        @(negedge clk);
        step();
        req_valid = 4'b0100;
        req_data[2*W +: W] = 48'h1234_5678_9ABC;
        @(negedge clk);
        step();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL kill_cycle(rst=%b): got rdy=%b busy=%b, need 0000 1", use_rst, req_ready, busy);
        end
        step();
        rst = 1'b0;
        flush = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_r = use_rst ? 4'b0001 : 4'b1000;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== exp_r) begin
            errors++;
            $display("FAIL kill_after(rst=%b): got v=%b busy=%b rdy=%b, need 0 0 %b",
                     use_rst, rsp_valid, busy, req_ready, exp_r);
        end
        step();
        drain();
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        logic [63:0]  r;
        acc = '0;
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i] && $urandom_range(0, 9) != 0)) begin
                    r = {$urandom(), $urandom()};
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_data[i*W +: W] = r[W-1:0];
                    req_shamt[i*AW +: AW] = AW'($urandom_range(0, 63));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = req_valid & req_ready;
        end
        step();
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_kill(1'b0);
        test_kill(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, need completion");
        $fatal(1, "timeout");
    end

endmodule
